vga_frame_capture: RTL and testbench

//  Sink end of the 640x480 VGA link. Recovers pixel position from incoming hsync/vsync,

---
 rtl/vga_frame_capture.sv | 157 +++++++++++++++
 tb/tb_vga_frame_capture.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/vga_frame_capture.sv
// VGA sink: recovers pixel position from hsync/vsync, expands 3-bit RGB to 24-bit and
// writes one IMG_W x IMG_H window of a single frame into a BRAM write port.
module vga_frame_capture #(
  parameter int H_BP   = 144,
  parameter int V_BP   = 31,
  parameter int IMG_X0 = 0,
  parameter int IMG_Y0 = 0,
  parameter int IMG_W  = 256,
  parameter int IMG_H  = 256,
  parameter int ADDR_W = 18
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              capture_req,
  input  logic              hsync,
  input  logic              vsync,
  input  logic [2:0]        red,
  input  logic [2:0]        green,
  input  logic [2:0]        blue,
  output logic              bram_we,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [23:0]       bram_din,
  output logic              busy,
  output logic              done,
  output logic              frame_err
);

  typedef enum logic [1:0] {IDLE, WAIT_VS, CAPTURE, DONE} state_e;

  localparam logic [10:0]       X_LO      = 11'(H_BP + IMG_X0);
  localparam logic [10:0]       X_HI      = 11'(H_BP + IMG_X0 + IMG_W);
  localparam logic [10:0]       Y_LO      = 11'(V_BP + IMG_Y0);
  localparam logic [10:0]       Y_HI      = 11'(V_BP + IMG_Y0 + IMG_H);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_W * IMG_H - 1);

  state_e              state_q, state_d;
  logic                hs1_q, hs1_d, hs2_q, hs2_d;
  logic                vs1_q, vs1_d, vs2_q, vs2_d;
  logic [8:0]          rgb1_q, rgb1_d, rgb2_q, rgb2_d;
  logic [9:0]          hc_q, hc_d, vc_q, vc_d;
  logic [ADDR_W-1:0]   addr_cnt_q, addr_cnt_d;
  logic                bram_we_q, bram_we_d;
  logic [ADDR_W-1:0]   bram_addr_q, bram_addr_d;
  logic [23:0]         bram_din_q, bram_din_d;
  logic                done_q, done_d;
  logic                frame_err_q, frame_err_d;

  logic h_edge, v_edge, hit;

  function automatic logic [7:0] expand(input logic [2:0] c);
    return {c, c, c[2:1]};
  endfunction

  assign h_edge = hs2_q & ~hs1_q;
  assign v_edge = vs2_q & ~vs1_q;
  // rgb2 is the pixel whose position is currently held in hc/vc.
  assign hit = ({1'b0, hc_q} >= X_LO) && ({1'b0, hc_q} < X_HI) &&
               ({1'b0, vc_q} >= Y_LO) && ({1'b0, vc_q} < Y_HI);

  // NOTE: every variable gets a default at the top of always_comb so no path leaves it
  // unassigned; that is what keeps this block from inferring latches.
  always_comb begin
    hs1_d       = hsync;
    vs1_d       = vsync;
    hs2_d       = hs1_q;
    vs2_d       = vs1_q;
    rgb1_d      = {red, green, blue};
    rgb2_d      = rgb1_q;
    hc_d        = (hc_q == 10'd1023) ? hc_q : hc_q + 10'd1;
    vc_d        = vc_q;
    state_d     = state_q;
    addr_cnt_d  = addr_cnt_q;
    bram_we_d   = 1'b0;
    bram_addr_d = bram_addr_q;
    bram_din_d  = bram_din_q;
    done_d      = 1'b0;
    frame_err_d = frame_err_q;

    if (h_edge) hc_d = '0;
    if (v_edge) vc_d = '0;
    else if (h_edge && vc_q != 10'd1023) vc_d = vc_q + 10'd1;

    case (state_q)
      IDLE: begin
        if (capture_req) begin
          state_d     = WAIT_VS;
          frame_err_d = 1'b0;
          addr_cnt_d  = '0;
        end
      end
      WAIT_VS: if (v_edge) state_d = CAPTURE;
      CAPTURE: begin
        if (v_edge) begin
          state_d     = IDLE;
          frame_err_d = 1'b1;
        end else if (hit) begin
          bram_we_d   = 1'b1;
          bram_addr_d = addr_cnt_q;
          bram_din_d  = {expand(rgb2_q[8:6]), expand(rgb2_q[5:3]), expand(rgb2_q[2:0])};
          addr_cnt_d  = addr_cnt_q + 1'b1;
          if (addr_cnt_q == LAST_ADDR) begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // values from before this edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      hs1_q       <= 1'b1;
      hs2_q       <= 1'b1;
      vs1_q       <= 1'b1;
      vs2_q       <= 1'b1;
      rgb1_q      <= '0;
      rgb2_q      <= '0;
      hc_q        <= '0;
      vc_q        <= '0;
      addr_cnt_q  <= '0;
      bram_we_q   <= 1'b0;
      bram_addr_q <= '0;
      bram_din_q  <= '0;
      done_q      <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hs1_q       <= hs1_d;
      hs2_q       <= hs2_d;
      vs1_q       <= vs1_d;
      vs2_q       <= vs2_d;
      rgb1_q      <= rgb1_d;
      rgb2_q      <= rgb2_d;
      hc_q        <= hc_d;
      vc_q        <= vc_d;
      addr_cnt_q  <= addr_cnt_d;
      bram_we_q   <= bram_we_d;
      bram_addr_q <= bram_addr_d;
      bram_din_q  <= bram_din_d;
      done_q      <= done_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign bram_we   = bram_we_q;
  assign bram_addr = bram_addr_q;
  assign bram_din  = bram_din_q;
  assign done      = done_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q == WAIT_VS) || (state_q == CAPTURE);

endmodule

// File: tb/tb_vga_frame_capture.sv
// Directed bench for vga_frame_capture on a shrunken 40x12 frame with an 8x4 window
// offset by (2,1): partial frame, full capture, early vsync abort, reset mid-capture.
module tb_vga_frame_capture;

  localparam int H_BP = 10, V_BP = 3, X0 = 2, Y0 = 1, W = 8, H = 4, AW = 6;
  localparam int H_TOT = 40, HS_LEN = 4, V_TOT = 12, VS_LEN = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          capture_req = 1'b0;
  logic          hsync, vsync;
  logic [2:0]    red, green, blue;
  logic          bram_we;
  logic [AW-1:0] bram_addr;
  logic [23:0]   bram_din;
  logic          busy, done, frame_err;

  int n_checks = 0;
  int n_fail   = 0;
  int gen_h = 0, gen_v = 6;
  int early_vs_at = -1;
  int writes = 0, exp_addr = 0, done_count = 0;
  logic [23:0] first_din = '0, last_din = '0;

  vga_frame_capture #(
    .H_BP(H_BP), .V_BP(V_BP), .IMG_X0(X0), .IMG_Y0(Y0),
    .IMG_W(W), .IMG_H(H), .ADDR_W(AW)
  ) dut (
    .clk(clk), .rst(rst), .capture_req(capture_req),
    .hsync(hsync), .vsync(vsync), .red(red), .green(green), .blue(blue),
    .bram_we(bram_we), .bram_addr(bram_addr), .bram_din(bram_din),
    .busy(busy), .done(done), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] exp8(input int c);
    logic [2:0] v;
    v = 3'(c);
    return {v, v, v[2:1]};
  endfunction

  // Pixel colour is a function of source position, so the bench can predict any address.
  function automatic logic [23:0] model_din(input int a);
    int x, y, ph, pv;
    x  = a % W;
    y  = a / W;
    ph = x + H_BP + X0;
    pv = y + V_BP + Y0;
    return {exp8(ph + 1), exp8(ph + pv + 3), exp8(pv)};
  endfunction

  task automatic drive_pins();
    hsync = (gen_h < HS_LEN) ? 1'b0 : 1'b1;
    vsync = (gen_v < VS_LEN) ? 1'b0 : 1'b1;
    red   = 3'(gen_h + 1);
    green = 3'(gen_h + gen_v + 3);
    blue  = 3'(gen_v);
  endtask

  initial begin
    drive_pins();
    forever begin
      @(negedge clk);
      if (gen_h == H_TOT - 1) begin
        gen_h = 0;
        if (gen_v == early_vs_at) begin
          gen_v = 0;
          early_vs_at = -1;
        end else begin
          gen_v = (gen_v == V_TOT - 1) ? 0 : gen_v + 1;
        end
      end else begin
        gen_h = gen_h + 1;
      end
      drive_pins();
    end
  end

  always @(negedge clk) begin
    if (bram_we) begin
      check("wr_addr", 32'(bram_addr), 32'(exp_addr));
      check("wr_din", 32'(bram_din), 32'(model_din(int'(bram_addr))));
      if (bram_addr == 0) first_din = bram_din;
      if (bram_addr == AW'(W * H - 1)) last_din = bram_din;
      writes++;
      exp_addr++;
    end
    if (done) done_count++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_pos(input int v, input int h, input string tag);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      tick();
      if (gen_v == v && gen_h == h) found = 1'b1;
    end
    if (!found) check(tag, 32'(found), 32'd1);
  endtask

  task automatic pulse_req();
    capture_req = 1'b1;
    tick();
    capture_req = 1'b0;
  endtask

  initial begin
    logic found;
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic found;
    repeat (3) tick();
    check("rst_we", 32'(bram_we), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(frame_err), 32'd0);
    check("rst_addr", 32'(bram_addr), 32'd0);
    check("rst_din", 32'(bram_din), 32'd0);
    rst = 1'b0;
    tick();

    // Arm mid-frame: the partial frame must produce nothing.
    pulse_req();
    check("armed_busy", 32'(busy), 32'd1);
    wait_pos(0, 0, "wait_frame0");
    check("partial_writes", 32'(writes), 32'd0);
    wait_pos(5, 0, "wait_mid");
    pulse_req();
    wait_pos(0, 0, "wait_frame1");
    check("full_writes", 32'(writes), 32'(W * H));
    check("full_done", 32'(done_count), 32'd1);
    check("full_busy", 32'(busy), 32'd0);
    check("full_err", 32'(frame_err), 32'd0);
    check("first_din", 32'(first_din), 32'h00B66D92);
    check("last_din", 32'(last_din), 32'h0092B6FF);

    // Early vsync after window line 2 aborts the capture.
    writes = 0; exp_addr = 0; done_count = 0;
    pulse_req();
    wait_pos(0, 0, "wait_frame2");
    early_vs_at = 6;
    wait_pos(0, 0, "wait_early_vs");
    repeat (5) tick();
    check("abort_err", 32'(frame_err), 32'd1);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_writes", 32'(writes), 32'(3 * W));
    check("abort_done", 32'(done_count), 32'd0);
    wait_pos(0, 0, "wait_frame3");
    check("idle_writes", 32'(writes), 32'(3 * W));
    check("sticky_err", 32'(frame_err), 32'd1);

    // Reset in the middle of a capture, then a clean restart from address 0.
    writes = 0; exp_addr = 0;
    pulse_req();
    check("req_clears_err", 32'(frame_err), 32'd0);
    wait_pos(0, 0, "wait_frame4");
    found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      tick();
      if (bram_we && bram_addr == AW'(10)) found = 1'b1;
    end
    check("reach_addr10", 32'(found), 32'd1);
    rst = 1'b1;
    tick();
    check("rst_mid_we", 32'(bram_we), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_err", 32'(frame_err), 32'd0);
    rst = 1'b0;
    tick();
    check("rst_mid_writes", 32'(writes), 32'd11);
    check("rst_mid_done", 32'(done_count), 32'd0);

    writes = 0; exp_addr = 0;
    pulse_req();
    wait_pos(0, 0, "wait_frame5");
    wait_pos(0, 0, "wait_frame6");
    check("restart_writes", 32'(writes), 32'(W * H));
    check("restart_done", 32'(done_count), 32'd1);
    check("restart_err", 32'(frame_err), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
